// File: rtl/neuron_mac_serial.sv
// Single neuron: serial signed MAC over NUM_INPUTS operands, bias add, saturation and a
// selectable activation, with runtime-loadable weights/bias and valid/ready ports.
module neuron_mac_serial #(
  parameter int INTEGRAL_WIDTH = 4,
  parameter int FRACTION_WIDTH = 16,
  parameter int NUM_INPUTS     = 8,
  localparam int W  = INTEGRAL_WIDTH + FRACTION_WIDTH,
  localparam int AW = $clog2(NUM_INPUTS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [W-1:0]  cfg_data,
  output logic          cfg_err,
  input  logic [1:0]    act_mode,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_sat
);

  localparam int F     = FRACTION_WIDTH;
  localparam int IW    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int ACC_W = 2 * W + $clog2(NUM_INPUTS) + 1;
  localparam int SUM_W = ACC_W + 1;

  localparam logic signed [SUM_W-1:0] S_MAX   = SUM_W'({1'b0, {(W-1){1'b1}}});
  localparam logic signed [SUM_W-1:0] S_MIN   = ~S_MAX;
  localparam logic signed [W:0]       ONE     = (W+1)'(1) <<< F;
  localparam logic signed [W:0]       HALF    = ONE >>> 1;
  localparam logic signed [W:0]       NEG_ONE = -ONE;

  typedef enum logic [1:0] {ST_ACCUM, ST_ACT, ST_OUT} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [W-1:0]     w_q [NUM_INPUTS];
  logic signed [W-1:0]     w_d [NUM_INPUTS];
  logic signed [W-1:0]     bias_q, bias_d;
  logic [W-1:0]            out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;
  logic                    out_valid_q, out_valid_d;
  logic                    cfg_err_q, cfg_err_d;

  logic signed [W-1:0]     w_sel;
  logic signed [2*W-1:0]   prod;
  logic signed [SUM_W-1:0] bias_sh, sum, s;
  logic signed [W-1:0]     x;
  logic signed [W:0]       x_e, hs;
  logic                    sat;
  logic [W-1:0]            y;

  always_comb begin
    w_sel = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (idx_q == IW'(i)) w_sel = w_q[i];
    end
    prod = (2*W)'(w_sel) * (2*W)'($signed(in_data));
  end

  // Bias is aligned to the product scale before the floor shift back to Q(I.F).
  always_comb begin
    bias_sh = SUM_W'(bias_q) <<< F;
    sum     = SUM_W'(acc_q) + bias_sh;
    s       = sum >>> F;
    sat     = 1'b0;
    if (s > S_MAX) begin
      x   = {1'b0, {(W-1){1'b1}}};
      sat = 1'b1;
    end else if (s < S_MIN) begin
      x   = {1'b1, {(W-1){1'b0}}};
      sat = 1'b1;
    end else begin
      x = s[W-1:0];
    end
    x_e = (W+1)'(x);
    hs  = (x_e >>> 2) + HALF;
    y   = x;
    unique case (act_mode)
      2'd0: y = x;
      2'd1: y = x[W-1] ? '0 : x;
      2'd2: begin
        if (hs[W])         y = '0;
        else if (hs > ONE) y = ONE[W-1:0];
        else               y = hs[W-1:0];
      end
      2'd3: begin
        if (x_e > ONE)          y = ONE[W-1:0];
        else if (x_e < NEG_ONE) y = NEG_ONE[W-1:0];
        else                    y = x;
      end
      default: y = x;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    w_d         = w_q;
    bias_d      = bias_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_valid_d = out_valid_q;
    cfg_err_d   = 1'b0;

    // Writes land only between results; out-of-range addresses are dropped silently.
    if (cfg_we && (cfg_addr <= AW'(NUM_INPUTS))) begin
      if ((state_q == ST_ACCUM) && (idx_q == '0)) begin
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
          if (cfg_addr == AW'(i)) w_d[i] = cfg_data;
        end
        if (cfg_addr == AW'(NUM_INPUTS)) bias_d = cfg_data;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    unique case (state_q)
      ST_ACCUM: begin
        if (in_valid) begin
          acc_d = acc_q + ACC_W'(prod);
          if (idx_q == IW'(NUM_INPUTS - 1)) begin
            idx_d   = '0;
            state_d = ST_ACT;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      ST_ACT: begin
        out_data_d  = y;
        out_sat_d   = sat;
        out_valid_d = 1'b1;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          state_d     = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ACCUM;
      idx_q       <= '0;
      acc_q       <= '0;
      bias_q      <= '0;
      for (int unsigned i = 0; i < NUM_INPUTS; i++) w_q[i] <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      bias_q      <= bias_d;
      w_q         <= w_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_valid_q <= out_valid_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign cfg_err   = cfg_err_q;

endmodule
